// File: rtl/steer_en_sm_if.sv
// steer_en_sm_if -- load-cell sample bus and steering-enable outputs.
//   ld_vld      : one-cycle strobe, lft_ld/rght_ld valid this cycle
//   lft_ld      : left load-cell reading, 12-bit unsigned
//   rght_ld     : right load-cell reading, 12-bit unsigned
//   en_steer    : steering enable to balance_cntrl (registered)
//   rider_off   : no rider present (registered, hysteresis)
//   steer_state : current FSM state, 00 IDLE / 01 WAIT / 10 STEER_EN
// master: sample producer / output consumer; slave: steer_en_sm.
interface steer_en_sm_if;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;
  logic [1:0]  steer_state;

  modport master (
    output ld_vld, lft_ld, rght_ld,
    input  en_steer, rider_off, steer_state
  );

  modport slave (
    input  ld_vld, lft_ld, rght_ld,
    output en_steer, rider_off, steer_state
  );
endinterface

// File: rtl/steer_en_sm.sv
// steer_en_sm -- rider-presence and steering-enable sequencer.
// Captures left/right load-cell samples, applies weight hysteresis and a
// settle timer, and drives rider_off / en_steer into balance_cntrl.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : steer_en_sm_if.slave (ld_vld, lft_ld, rght_ld in;
//           en_steer, rider_off, steer_state out)
// Parameters: FAST_SIM (1 -> 15-bit settle timer, 0 -> 26-bit),
//             MIN_RIDER_WT, WT_HYSTERESIS.
// Optional feature macro: RIDER_OFF_FILTER_EN -- rider_off and the FSM exit
// to IDLE require 4 consecutive light samples instead of one.
module steer_en_sm #(
  parameter bit          FAST_SIM      = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
  input  logic         clk,
  input  logic         rst_n,
  steer_en_sm_if.slave bus
);

  localparam int unsigned TMR_W = FAST_SIM ? 15 : 26;
  localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
  localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT     = 2'b01,
    STEER_EN = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [11:0]        lft_q, rght_q;
  logic               en_steer_q, en_steer_d;
  logic               rider_off_q, rider_off_d;

  logic [12:0]        sum, diff;
  logic               sum_gt_min, sum_lt_min;
  logic               diff_gt_1_4, diff_gt_15_16;
  logic               tmr_full;
  logic               off_cond;

  // Sample stage: all decisions use the held sample, one clock after ld_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (bus.ld_vld) begin
      lft_q  <= bus.lft_ld;
      rght_q <= bus.rght_ld;
    end
  end

  always_comb begin
    sum           = {1'b0, lft_q} + {1'b0, rght_q};
    diff          = (lft_q >= rght_q) ? ({1'b0, lft_q} - {1'b0, rght_q})
                                      : ({1'b0, rght_q} - {1'b0, lft_q});
    sum_gt_min    = sum > THR_HI;
    sum_lt_min    = sum < THR_LO;
    diff_gt_1_4   = diff > (sum >> 2);
    diff_gt_15_16 = diff > (sum - (sum >> 4));
    tmr_full      = &tmr_q;
  end

`ifdef RIDER_OFF_FILTER_EN
  // lt_cnt_q counts consecutive light samples *preceding* the one now held
  // (saturating at 3); it is advanced from the outgoing sample when a new
  // strobe arrives. The held sample is therefore the 4th light one exactly
  // when lt_cnt_q == 3 and it is itself light. smp_seen_q keeps the reset
  // contents of lft_q/rght_q from counting as a sample.
  logic [1:0] lt_cnt_q;
  logic       smp_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_cnt_q   <= '0;
      smp_seen_q <= 1'b0;
    end else if (bus.ld_vld) begin
      smp_seen_q <= 1'b1;
      if (smp_seen_q && sum_lt_min)
        lt_cnt_q <= (lt_cnt_q == 2'd3) ? 2'd3 : lt_cnt_q + 2'd1;
      else
        lt_cnt_q <= '0;
    end
  end

  assign off_cond = sum_lt_min && (lt_cnt_q == 2'd3);
`else
  assign off_cond = sum_lt_min;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
    end
  end

  // Next-state; timer defaults to 0, so it is cleared on WAIT entry and
  // held at 0 everywhere outside WAIT.
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (sum_gt_min) state_d = WAIT;
      end
      WAIT: begin
        if (off_cond)         state_d = IDLE;
        else if (diff_gt_1_4) state_d = WAIT;
        else if (tmr_full)    state_d = STEER_EN;
        else                  tmr_d   = tmr_q + TMR_W'(1);
      end
      STEER_EN: begin
        if (off_cond)           state_d = IDLE;
        else if (diff_gt_15_16) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs (registered on the same edge as the state)
  always_comb begin
    en_steer_d  = (state_d == STEER_EN);
    rider_off_d = rider_off_q;
    if (off_cond)        rider_off_d = 1'b1;
    else if (sum_gt_min) rider_off_d = 1'b0;
  end

  assign bus.en_steer    = en_steer_q;
  assign bus.rider_off   = rider_off_q;
  assign bus.steer_state = state_q;

endmodule

// File: doc/steer_en_sm.md
Name: steer_en_sm

Overview:
Rider-presence and steering-enable sequencer for the Segway balance datapath. It consumes the two load-cell readings (left/right platform weight) from the A2D interface and decides when a rider is on board and standing squarely. It drives rider_off and en_steer into balance_cntrl, so it gates both the PID integrator and the steering mix. It debounces rider mount with a settle timer and applies hysteresis on the weight thresholds.

Parameters:
FAST_SIM, 1, selects settle timer width: 1 -> 15 bits (sim), 0 -> 26 bits (~1.34 s at 50 MHz)
MIN_RIDER_WT, 12'h200, nominal minimum total rider weight in load-cell counts
WT_HYSTERESIS, 12'h040, half-width of the hysteresis band around MIN_RIDER_WT

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ld_vld  input  1  one-cycle strobe; lft_ld/rght_ld are valid this cycle
lft_ld  input  12  left load-cell reading, unsigned
rght_ld  input  12  right load-cell reading, unsigned
en_steer  output  1  steering enable to balance_cntrl, registered
rider_off  output  1  no rider present, registered
steer_state  output  2  current FSM state (00 IDLE, 01 WAIT, 10 STEER_EN), for debug/verification

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, timer 0, sample registers 0, en_steer 0, rider_off 1.
- Sample stage: on ld_vld, lft_ld/rght_ld are captured into lft_q/rght_q. All decisions use lft_q/rght_q, giving 1 clock of latency from ld_vld. Samples hold between strobes.
- Arithmetic: sum = lft_q + rght_q (13-bit unsigned, no overflow); diff = |lft_q - rght_q| (13-bit magnitude).
- Flags (all comparisons strict):
  - sum_gt_min = sum > MIN_RIDER_WT + WT_HYSTERESIS (576 at defaults)
  - sum_lt_min = sum < MIN_RIDER_WT - WT_HYSTERESIS (448 at defaults)
  - diff_gt_1_4 = diff > (sum >> 2)
  - diff_gt_15_16 = diff > sum - (sum >> 4)
- Settle timer: counts +1 every clk while in WAIT and not cleared. tmr_full = all ones (32767 when FAST_SIM=1). Cleared on entry to WAIT and whenever diff_gt_1_4 in WAIT. Held at 0 outside WAIT.
- FSM, evaluated every clk, priority in listed order:
  - IDLE: sum_gt_min -> WAIT (clear timer); otherwise stay.
  - WAIT: sum_lt_min -> IDLE. Else diff_gt_1_4 -> stay, clear timer. Else tmr_full -> STEER_EN. Else stay, increment.
  - STEER_EN: sum_lt_min -> IDLE. Else diff_gt_15_16 -> WAIT (clear timer). Else stay.
- en_steer: registered; updates on the same edge as state; 1 exactly when next state is STEER_EN.
- rider_off: registered with hysteresis. Set when sum_lt_min. Cleared when sum_gt_min. Otherwise holds. Independent of FSM state.
- Sums inside the hysteresis band (448..576): no state change from IDLE or STEER_EN; WAIT continues per diff rules.
- Asserting rst_n low mid-operation: immediate return to reset values, no partial timer retention.
- Simultaneous ld_vld and a transition: the transition uses the old lft_q/rght_q; the new sample acts next cycle.

Optional Feature:
RIDER_OFF_FILTER_EN
- Defined: rider_off sets only after sum_lt_min has held on 4 consecutive ld_vld samples (2-bit counter, cleared by any sample with sum_lt_min false). The FSM exit to IDLE uses the same filtered condition.
- Undefined: single-sample behaviour as in Behaviour.

Test Plan:
- Reset, then lft=rght=0x180 with ld_vld every 16 clks -> rider_off falls 2 clks after first strobe; state WAIT; en_steer 0 for ≥32767 clks, rises by clk 32771; state 10.
- Platform loaded lft=0x200, rght=0x080 (sum 640, diff 384 > 160) for 100000 clks -> state stays WAIT, timer never exceeds 1, en_steer stays 0, rider_off 0.
- From STEER_EN, sample lft=0x300, rght=0x010 (sum 784, diff 752 > 735) -> 1 clk later state WAIT, en_steer 0, timer 0. Return to balanced -> en_steer re-rises after 32768 clks.
- From STEER_EN, sample sum=500 (lft=0x0FA, rght=0x0FA) -> no change, en_steer 1, rider_off 0. Then sum=416 (0x0D0 each) -> IDLE, en_steer 0, rider_off 1 on the same edge.
- Assert rst_n low during WAIT at timer ~20000 -> outputs immediately en_steer 0, rider_off 1, state 00. Release and keep the balanced load -> full 32767-clk settle required again.
- With RIDER_OFF_FILTER_EN: 3 light samples (sum 416) then 1 of 768 -> rider_off stays 0, STEER_EN held. 4 consecutive light samples -> rider_off 1, IDLE.
